// File: rtl/corevx_muldiv_pkg.sv
// Shared definitions for the corevx multi-cycle RV32M multiply/divide unit:
// funct3 encodings, the FSM state type and the overflow/divide-by-zero constants.
package corevx_muldiv_pkg;

    localparam logic [2:0] FunctMul    = 3'b000;
    localparam logic [2:0] FunctMulh   = 3'b001;
    localparam logic [2:0] FunctMulhsu = 3'b010;
    localparam logic [2:0] FunctMulhu  = 3'b011;
    localparam logic [2:0] FunctDiv    = 3'b100;
    localparam logic [2:0] FunctDivu   = 3'b101;
    localparam logic [2:0] FunctRem    = 3'b110;
    localparam logic [2:0] FunctRemu   = 3'b111;

    localparam logic [31:0] MinNeg  = 32'h8000_0000;
    localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // REM/REMU share bit pattern 11x; only meaningful when op_is_div is set.
    function automatic logic op_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/corevx_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module corevx_divider_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            quot_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          unused_diff_msb;

    assign shifted    = {rem_i, dividend_bit_i};
    assign diff       = shifted - {1'b0, divisor_i};
    assign quot_bit_o = (shifted >= {1'b0, divisor_i});
    // A non-borrowing difference is below the divisor, so its top bit is always zero.
    assign rem_o           = quot_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign unused_diff_msb = diff[XLEN];

endmodule

// File: rtl/corevx_muldiv.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider sharing one
// 64-bit accumulator, with valid/ready request and result handshakes.
module corevx_muldiv
    import corevx_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_operand0_i,
    input  logic [XLEN-1:0] req_operand1_i,
    input  logic            kill_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_data_o
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN);

    muldiv_state_e     state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              sign_q, sign_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;

    // Multiplier: acc holds {partial product, remaining multiplier bits}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod_fix;

    // Divider: acc holds {partial remainder, dividend bits shifting into quotient}.
    logic [XLEN-1:0]   div_rem;
    logic              div_qbit;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    logic              s0, s1, neg0, neg1;
    logic [XLEN-1:0]   mag0, mag1;
    logic              acc_div, acc_rem;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign prod_fix = sign_q ? -acc_q : acc_q;

    corevx_divider_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i          (acc_q[2*XLEN-1:XLEN]),
        .dividend_bit_i (acc_q[XLEN-1]),
        .divisor_i      (opnd_q),
        .rem_o          (div_rem),
        .quot_bit_o     (div_qbit)
    );

    assign div_next = {div_rem, acc_q[XLEN-2:0], div_qbit};
    assign quot_fix = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    assign s0 = (req_funct3_i == FunctMul) || (req_funct3_i == FunctMulh) ||
                (req_funct3_i == FunctMulhsu) || (req_funct3_i == FunctDiv) ||
                (req_funct3_i == FunctRem);
    assign s1 = (req_funct3_i == FunctMul) || (req_funct3_i == FunctMulh) ||
                (req_funct3_i == FunctDiv) || (req_funct3_i == FunctRem);
    assign neg0    = s0 & req_operand0_i[XLEN-1];
    assign neg1    = s1 & req_operand1_i[XLEN-1];
    assign mag0    = neg0 ? -req_operand0_i : req_operand0_i;
    assign mag1    = neg1 ? -req_operand1_i : req_operand1_i;
    assign acc_div = op_is_div(req_funct3_i);
    assign acc_rem = op_is_rem(req_funct3_i);

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        sign_d   = sign_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && !kill_i) begin
                    funct3_d = req_funct3_i;
                    cnt_d    = '0;
                    sign_d   = acc_rem ? neg0 : (neg0 ^ neg1);
                    if (acc_div) begin
                        opnd_d = mag1;
                        acc_d  = {{XLEN{1'b0}}, mag0};
                    end else begin
                        opnd_d = mag0;
                        acc_d  = {{XLEN{1'b0}}, mag1};
                    end
                    if (acc_div && (req_operand1_i == '0)) begin
                        state_d = StDone;
                        res_d   = acc_rem ? req_operand0_i : AllOnes;
                    end else if (acc_div && s0 && (req_operand0_i == MinNeg) &&
                                 (req_operand1_i == AllOnes)) begin
                        state_d = StDone;
                        res_d   = acc_rem ? '0 : MinNeg;
                    end else begin
                        state_d = acc_div ? StDiv : StMul;
                    end
                end
            end
            StMul: begin
                if (kill_i) begin
                    state_d = StIdle;
                end else if (cnt_q != CntLast) begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    res_d   = (funct3_q == FunctMul) ? prod_fix[XLEN-1:0]
                                                     : prod_fix[2*XLEN-1:XLEN];
                    state_d = StDone;
                end
            end
            StDiv: begin
                if (kill_i) begin
                    state_d = StIdle;
                end else if (cnt_q != CntLast) begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    res_d   = funct3_q[1] ? rem_fix : quot_fix;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (kill_i || res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            funct3_q <= '0;
            sign_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            sign_q   <= sign_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign res_valid_o = (state_q == StDone);
    assign res_data_o  = res_q;

endmodule
